// File: rtl/idx_mask_assembler_pkg.sv
// Shared definitions for the index-to-mask receive path: FSM states and default index width.
package idx_mask_assembler_pkg;

  localparam int unsigned IDXW_DEF = 3;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/idx_mask_assembler_onehot.sv
// Combinational IDXW -> 2**IDXW one-hot decoder.
module idx_onehot #(
  parameter int unsigned IDXW = 3
) (
  input  logic [IDXW-1:0]      i_idx,
  output logic [(1<<IDXW)-1:0] o_onehot
);

  localparam int unsigned WIDTH = 1 << IDXW;

  always_comb begin
    o_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << i_idx;
  end

endmodule

// File: rtl/idx_mask_assembler.sv
// Rebuilds a bit vector from a stream of priority-encoded indices, one frame at a time,
// flagging repeated and non-descending indices.
module idx_mask_assembler
  import idx_mask_assembler_pkg::*;
#(
  parameter int unsigned IDXW = IDXW_DEF
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDXW-1:0]      in_idx,
  input  logic                 in_empty,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(1<<IDXW)-1:0] out_mask,
  output logic [IDXW:0]        out_count,
  output logic                 out_dup_err,
  output logic                 out_order_err
);

  localparam int unsigned WIDTH = 1 << IDXW;

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_mask, w_mask_nxt;
  logic [IDXW:0]     r_count, w_count_nxt;
  logic              r_dup, w_dup_nxt;
  logic              r_order, w_order_nxt;
  logic [IDXW-1:0]   r_prev, w_prev_nxt;
  logic              r_first, w_first_nxt;

  logic [WIDTH-1:0]  w_bit;
  logic              w_accept;
  logic              w_release;
  logic              w_dup_hit;
  logic              w_order_hit;

  idx_onehot #(.IDXW(IDXW)) u_onehot (
    .i_idx    (in_idx),
    .o_onehot (w_bit)
  );

  assign w_accept    = (r_state == ST_ACCUM) && in_valid;
  assign w_release   = (r_state == ST_HOLD) && out_ready;
  assign w_dup_hit   = |(r_mask & w_bit);
  assign w_order_hit = !r_first && (in_idx >= r_prev);

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_count_nxt = r_count;
    w_dup_nxt   = r_dup;
    w_order_nxt = r_order;
    w_prev_nxt  = r_prev;
    w_first_nxt = r_first;

    if (w_accept) begin
      if (!in_empty) begin
        w_mask_nxt  = r_mask | w_bit;
        w_count_nxt = r_count + {{IDXW{1'b0}}, ~w_dup_hit};
        w_dup_nxt   = r_dup | w_dup_hit;
        w_order_nxt = r_order | w_order_hit;
        w_prev_nxt  = in_idx;
        w_first_nxt = 1'b0;
      end
      if (in_last) begin
        w_state_nxt = ST_HOLD;
      end
    end else if (w_release) begin
      w_state_nxt = ST_ACCUM;
      w_mask_nxt  = '0;
      w_count_nxt = '0;
      w_dup_nxt   = 1'b0;
      w_order_nxt = 1'b0;
      w_prev_nxt  = '0;
      w_first_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= ST_ACCUM;
      r_mask  <= '0;
      r_count <= '0;
      r_dup   <= 1'b0;
      r_order <= 1'b0;
      r_prev  <= '0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_count <= w_count_nxt;
      r_dup   <= w_dup_nxt;
      r_order <= w_order_nxt;
      r_prev  <= w_prev_nxt;
      r_first <= w_first_nxt;
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);

  // Partial accumulator contents stay hidden until the frame is complete.
  assign out_mask      = out_valid ? r_mask  : '0;
  assign out_count     = out_valid ? r_count : '0;
  assign out_dup_err   = out_valid & r_dup;
  assign out_order_err = out_valid & r_order;

endmodule

// File: tb/tb_idx_mask_assembler.sv
// Randomized frame bench for idx_mask_assembler with a set-based reference model.
module tb_idx_mask_assembler;

  localparam int unsigned IDXW  = 3;
  localparam int unsigned WIDTH = 1 << IDXW;

  logic             CLK = 1'b0;
  logic             CLR = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IDXW-1:0]  in_idx = '0;
  logic             in_empty = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_mask;
  logic [IDXW:0]    out_count;
  logic             out_dup_err;
  logic             out_order_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned f_idx[$];
  bit          f_emp[$];

  idx_mask_assembler #(.IDXW(IDXW)) dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_idx        (in_idx),
    .in_empty      (in_empty),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mask      (out_mask),
    .out_count     (out_count),
    .out_dup_err   (out_dup_err),
    .out_order_err (out_order_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic add_beat(input int unsigned idx, input bit emp);
    f_idx.push_back(idx);
    f_emp.push_back(emp);
  endtask

  // Entered and left at a falling edge; queues hold the frame, last beat is the final entry.
  task automatic run_frame(input string name, input int unsigned stall);
    logic [WIDTH-1:0] e_mask;
    int unsigned      e_count, nonempty, prev;
    bit               have_prev, e_order, e_dup;
    int unsigned      waits;

    e_mask = '0; nonempty = 0; prev = 0; have_prev = 0; e_order = 0;
    foreach (f_idx[i]) begin
      if (!f_emp[i]) begin
        if (have_prev && f_idx[i] >= prev) e_order = 1;
        prev      = f_idx[i];
        have_prev = 1;
        e_mask[f_idx[i]] = 1'b1;
        nonempty++;
      end
    end
    e_count = $countones(e_mask);
    e_dup   = (nonempty != e_count);

    foreach (f_idx[i]) begin
      repeat ($urandom_range(0, 1)) begin
        in_valid = 1'b0;
        in_idx   = IDXW'($urandom);
        in_last  = 1'($urandom);
        in_empty = 1'($urandom);
        @(negedge CLK);
      end
      waits = 0;
      while (!in_ready && waits < 20) begin
        @(negedge CLK);
        waits++;
      end
      check({name, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_idx   = IDXW'(f_idx[i]);
      in_empty = f_emp[i];
      in_last  = (i == f_idx.size() - 1);
      @(negedge CLK);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i != f_idx.size() - 1) begin
        check({name, " mid out_valid"}, 32'(out_valid), 32'd0);
        check({name, " mid out_mask"}, 32'(out_mask), 32'd0);
      end
    end

    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " hold in_ready"}, 32'(in_ready), 32'd0);
    check({name, " mask"}, 32'(out_mask), 32'(e_mask));
    check({name, " count"}, 32'(out_count), e_count);
    check({name, " dup"}, 32'(out_dup_err), 32'(e_dup));
    check({name, " order"}, 32'(out_order_err), 32'(e_order));

    repeat (stall) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_idx    = IDXW'($urandom);
      in_empty  = 1'($urandom);
      in_last   = 1'($urandom);
      @(negedge CLK);
      check({name, " stall in_ready"}, 32'(in_ready), 32'd0);
      check({name, " stall valid"}, 32'(out_valid), 32'd1);
      check({name, " stall mask"}, 32'(out_mask), 32'(e_mask));
      check({name, " stall count"}, 32'(out_count), e_count);
    end

    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check({name, " drain valid"}, 32'(out_valid), 32'd0);
    check({name, " drain in_ready"}, 32'(in_ready), 32'd1);
    check({name, " drain mask"}, 32'(out_mask), 32'd0);
    check({name, " drain count"}, 32'(out_count), 32'd0);
    check({name, " drain errs"}, {30'd0, out_dup_err, out_order_err}, 32'd0);

    f_idx.delete();
    f_emp.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] rmask;
    int unsigned      nb;

    repeat (2) @(negedge CLK);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset mask", 32'(out_mask), 32'd0);
    check("reset count", 32'(out_count), 32'd0);
    CLR = 1'b1;
    @(negedge CLK);

    add_beat(7, 0); add_beat(4, 0); add_beat(1, 0);
    run_frame("f741", 0);
    add_beat(0, 1);
    run_frame("empty", 0);
    add_beat(5, 0); add_beat(5, 0); add_beat(2, 0);
    run_frame("f552", 1);
    add_beat(2, 0); add_beat(6, 0);
    run_frame("f26", 0);
    add_beat(6, 0); add_beat(0, 1); add_beat(3, 0);
    run_frame("stall5", 5);
    add_beat(3, 0);
    run_frame("f3", 0);
    add_beat(7, 0); add_beat(6, 0); add_beat(5, 0); add_beat(4, 0);
    add_beat(3, 0); add_beat(2, 0); add_beat(1, 0); add_beat(0, 0);
    run_frame("full", 0);

    // Abandon a partial frame via reset.
    in_valid = 1'b1; in_empty = 1'b0; in_last = 1'b0;
    in_idx = 3'd6; @(negedge CLK);
    in_idx = 3'd3; @(negedge CLK);
    in_valid = 1'b0;
    #2 CLR = 1'b0;
    #1;
    check("clr out_valid", 32'(out_valid), 32'd0);
    check("clr in_ready", 32'(in_ready), 32'd1);
    check("clr mask", 32'(out_mask), 32'd0);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    add_beat(0, 0);
    run_frame("post_clr", 0);

    // Reset while a completed frame is being held.
    in_valid = 1'b1; in_idx = 3'd4; in_empty = 1'b0; in_last = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0;
    check("hold before clr", 32'(out_valid), 32'd1);
    #2 CLR = 1'b0;
    #1;
    check("clr hold valid", 32'(out_valid), 32'd0);
    check("clr hold count", 32'(out_count), 32'd0);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    add_beat(1, 0);
    run_frame("post_clr2", 0);

    for (int k = 0; k < 40; k++) begin
      nb = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1) begin
        rmask = WIDTH'($urandom);
        for (int b = WIDTH - 1; b >= 0; b--) begin
          if (rmask[b]) add_beat(b, 0);
          if ($urandom_range(0, 7) == 0) add_beat($urandom_range(0, WIDTH - 1), 1);
        end
        if (f_idx.size() == 0) add_beat(0, 1);
      end else begin
        for (int b = 0; b < int'(nb); b++)
          add_beat($urandom_range(0, WIDTH - 1), ($urandom_range(0, 4) == 0));
      end
      run_frame($sformatf("rnd%0d", k), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
